// File: rtl/imm_ext_pkg.sv
// Shared constants for the decode-stage immediate extender: mode encodings and mode-field width.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ZEXT     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SEXT     = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SEXT_SHL = 2'b10;
  localparam logic [MODE_W-1:0] MODE_UPPER    = 2'b11;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry valid/ready skid buffer with flush; 1-cycle latency, in_ready is registered
// (depends only on skid occupancy and flush), so out_ready never reaches in_ready combinationally.
module ext_skid_buf #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic [W-1:0] main_dat;
  logic         skid_vld;
  logic [W-1:0] skid_dat;
  logic         accept;
  logic         take;

  assign in_ready  = !skid_vld && !flush;
  assign accept    = in_valid && in_ready;
  // A flush cycle ignores the consumer's take as well as the producer's beat.
  assign take      = main_vld && out_ready && !flush;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (take) begin
      if (skid_vld) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_dat <= in_data;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (main_vld) begin
        skid_dat <= in_data;
        skid_vld <= 1'b1;
      end else begin
        main_dat <= in_data;
        main_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/imm_extender_pipe.sv
// Multi-mode immediate extender: combinational extend, registered through a 2-entry skid buffer
// (1-cycle latency, full throughput; in_ready drops only when the skid entry is occupied or on flush).
module imm_extender_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32,
  parameter int ZW    = 17,
  parameter int SHIFT = 2,
  parameter int UP_W  = 16,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  if (OUT_W < IN_W + SHIFT || ZW > IN_W || UP_W > OUT_W) begin : g_param_check
    $error("imm_extender_pipe: illegal parameter combination");
  end

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] sext_shl;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] ext;

  assign zext     = {{(OUT_W-ZW){1'b0}}, in_data[ZW-1:0]};
  assign sext     = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign sext_shl = sext << SHIFT;
  assign upper    = {in_data[UP_W-1:0], {(OUT_W-UP_W){1'b0}}};

  always_comb begin
    ext = zext;
    case (in_mode)
      MODE_ZEXT:     ext = zext;
      MODE_SEXT:     ext = sext;
      MODE_SEXT_SHL: ext = sext_shl;
      MODE_UPPER:    ext = upper;
      default:       ext = zext;
    endcase
  end

  ext_skid_buf #(
    .W(OUT_W + TAG_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ext, in_tag}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_data, out_tag})
  );

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Directed and randomised self-checking bench for imm_extender_pipe (default parameters).
module tb_imm_extender_pipe;

  localparam int IN_W  = 18;
  localparam int OUT_W = 32;
  localparam int ZW    = 17;
  localparam int SHIFT = 2;
  localparam int UP_W  = 16;
  localparam int TAG_W = 5;
  localparam int NBEATS = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;

  int checks = 0;
  int errors = 0;

  imm_extender_pipe #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ZW(ZW), .SHIFT(SHIFT), .UP_W(UP_W), .TAG_W(TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m,
                       input logic [TAG_W-1:0] t);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
  endtask

  // Reference extension using plain integer arithmetic.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint sx;
    longint ud;
    sx = longint'($signed(d));
    ud = longint'(d);
    case (m)
      2'd0:    return OUT_W'(ud & ((64'd1 << ZW) - 1));
      2'd1:    return OUT_W'(sx);
      2'd2:    return OUT_W'(sx * (64'd1 << SHIFT));
      default: return OUT_W'((ud & ((64'd1 << UP_W) - 1)) << (OUT_W - UP_W));
    endcase
  endfunction

  logic [OUT_W+TAG_W-1:0] sb[$];
  logic [OUT_W+TAG_W-1:0] exp_beat;
  int sent;
  int got;
  int cyc;
  bit accepted;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, 2'd0, '0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Four modes back to back, out_ready=1.
    drive(1'b1, 18'h3FFFF, 2'b00, 5'd1);
    tick();
    check("zext_valid", out_valid, 1);
    check("zext_data", out_data, 32'h0001FFFF);
    check("zext_tag", out_tag, 1);
    drive(1'b1, 18'h20000, 2'b01, 5'd2);
    tick();
    check("sext_data", out_data, 32'hFFFE0000);
    check("sext_tag", out_tag, 2);
    drive(1'b1, 18'h3FFFF, 2'b10, 5'd3);
    tick();
    check("sshl_data", out_data, 32'hFFFFFFFC);
    check("sshl_tag", out_tag, 3);
    drive(1'b1, 18'h0ABCD, 2'b11, 5'd4);
    tick();
    check("upper_data", out_data, 32'hABCD0000);
    check("upper_tag", out_tag, 4);
    drive(1'b0, '0, 2'd0, '0);
    tick();
    check("modes_drain", out_valid, 0);

    // Streaming: 8 beats on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, IN_W'(i), 2'b00, TAG_W'(i));
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_tag", out_tag, i);
    end
    drive(1'b0, '0, 2'd0, '0);
    tick();
    check("stream_drain", out_valid, 0);

    // Backpressure: three beats offered, two accepted.
    out_ready = 1'b0;
    drive(1'b1, 18'd1, 2'b00, 5'd11);
    tick();
    check("bp_b1_tag", out_tag, 11);
    check("bp_rdy_after1", in_ready, 1);
    drive(1'b1, 18'd2, 2'b00, 5'd12);
    tick();
    check("bp_rdy_after2", in_ready, 0);
    drive(1'b1, 18'd3, 2'b00, 5'd13);
    tick();
    check("bp_rdy_stall", in_ready, 0);
    check("bp_stable_data", out_data, 1);
    check("bp_stable_tag", out_tag, 11);
    out_ready = 1'b1;
    tick();
    check("bp_out2_tag", out_tag, 12);
    check("bp_out2_data", out_data, 2);
    check("bp_rdy_reopen", in_ready, 1);
    tick();
    check("bp_out3_tag", out_tag, 13);
    check("bp_out3_data", out_data, 3);
    drive(1'b0, '0, 2'd0, '0);
    tick();
    check("bp_drain", out_valid, 0);

    // Flush with both entries full and a beat on the input.
    out_ready = 1'b0;
    drive(1'b1, 18'd21, 2'b00, 5'd21);
    tick();
    drive(1'b1, 18'd22, 2'b00, 5'd22);
    tick();
    check("fl_full", in_ready, 0);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 18'd23, 2'b00, 5'd23);
    #1;
    check("fl_in_ready_low", in_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 2'd0, '0);
    #1;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready_back", in_ready, 1);
    tick();
    check("fl_no_ghost", out_valid, 0);

    // Async reset pulse between edges.
    out_ready = 1'b0;
    drive(1'b1, 18'd25, 2'b00, 5'd25);
    tick();
    drive(1'b0, '0, 2'd0, '0);
    check("ar_loaded", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_out_tag", out_tag, 0);
    check("ar_in_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 18'h20001, 2'b01, 5'd26);
    tick();
    check("ar_after_valid", out_valid, 1);
    check("ar_after_data", out_data, 32'hFFFE0001);
    check("ar_after_tag", out_tag, 26);
    drive(1'b0, '0, 2'd0, '0);
    tick();

    // Random valid/ready scoreboard.
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < NBEATS && cyc < 60000) begin
      if (!in_valid && sent < NBEATS && $urandom_range(0, 3) != 0)
        drive(1'b1, IN_W'($urandom), 2'($urandom), TAG_W'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      accepted = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rand_unexpected_beat", {out_data, out_tag}, '1);
        end else begin
          exp_beat = sb.pop_front();
          check("rand_beat", {out_data, out_tag}, exp_beat);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({model(in_data, in_mode), in_tag});
        sent++;
        accepted = 1'b1;
      end
      tick();
      cyc++;
      if (accepted) in_valid = 1'b0;
    end
    check("rand_count", got, NBEATS);
    check("rand_leftover", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
